pulpino_fpga_io_cond: RTL
=========================

// Module: pulpino_fpga_io_cond
// PURPOSE
//  FPGA-side pad conditioner between board pins and pulpino_top; successor to the fixed-tie FPGA wrapper.
//  NUM_GPIO-wide input path: synchroniser, per-channel programmable debounce, registered edge pulses.
//  Also a fetch-enable start sequencer: core fetch held off for FETCH_DLY cycles after reset.
//  gpio_o drives pulpino_top gpio_in; fetch_enable_o drives fetch_enable_i.
// PARAMETERS
//  NUM_GPIO     32    number of conditioned GPIO input channels
//  SYNC_STAGES  2     synchroniser depth, >=2
//  DEB_CNT_W    16    debounce counter / limit width
//  FETCH_DLY    1024  cycles after reset release before fetch may be enabled; 0 = no delay
// PORTS
//  clk                 in   1            system clock; single clock domain
//  rst_n               in   1            asynchronous reset, active-low
//  gpio_pad_i          in   NUM_GPIO     raw asynchronous board inputs
//  deb_en_i            in   NUM_GPIO     per-channel debounce enable
//  deb_limit_i         in   DEB_CNT_W    stable-cycle count L, shared by all channels
//  gpio_o              out  NUM_GPIO     conditioned level to SoC
//  rise_o / fall_o     out  NUM_GPIO     1-cycle pulse on gpio_o 0->1 / 1->0
//  fetch_enable_pad_i  in   1            raw fetch-enable switch
//  fetch_enable_o      out  1            sequenced fetch enable to SoC
//  irq_rise_en_i       in   NUM_GPIO     rising-edge capture enable
//  irq_fall_en_i       in   NUM_GPIO     falling-edge capture enable
//  irq_clr_i           in   NUM_GPIO     write-1-to-clear of edge_status_o
//  edge_status_o       out  NUM_GPIO     sticky captured edges
//  irq_o               out  1            OR of edge_status_o, registered
// BEHAVIOUR
//  Reset: all sync flops, gpio_o, rise_o, fall_o, counters, edge_status_o, irq_o, fetch_enable_o = 0; FSM = WAIT.
//  Sync: s[i] = gpio_pad_i[i] after SYNC_STAGES flops.
//  Debounce per channel, effective limit Le = (deb_en_i[i] && L>1) ? L : 1:
//   - s==gpio_o: cnt<=0.
//   - else if cnt>=Le-1: gpio_o<=s, cnt<=0.
//   - else cnt<=cnt+1.
//   - cnt never exceeds Le-1; lowering L mid-count updates on the next mismatched cycle.
//  Latency pad->gpio_o: SYNC_STAGES+Le edges; a glitch shorter than Le cycles never reaches gpio_o.
//  rise_o/fall_o: set on the same edge that updates gpio_o; high exactly 1 cycle.
//  Fetch FSM, pad synchronised through SYNC_STAGES flops, no debounce:
//   - WAIT: count FETCH_DLY cycles -> IDLE; FETCH_DLY=0 -> IDLE after first edge.
//   - IDLE: synced pad=1 -> RUN.
//   - RUN: synced pad=0 -> IDLE.
//   - fetch_enable_o registered, 1 only in RUN.
//   - Pad high during WAIT: RUN entered on the edge after WAIT exits.
//  Reset mid-operation: everything returns to reset values; sequence restarts from WAIT.
// CONFIGURATION
//  Macro GPIO_COND_IRQ_EN:
//   Defined:
//    - edge_status_o[i] set on rise_o&irq_rise_en_i or fall_o&irq_fall_en_i; cleared by irq_clr_i[i].
//    - Simultaneous set and clear: set wins.
//    - irq_o <= |edge_status_o, one cycle after status.
//   Undefined: edge_status_o and irq_o tied 0; enables and clears ignored. Ports stay present.
// STRUCTURE
//  Package pulpino_fpga_pkg:
//   - fetch_state_e {WAIT, IDLE, RUN}
//   - default constants for SYNC_STAGES, DEB_CNT_W, FETCH_DLY
//  Sub-module pulpino_gpio_deb_ch: one channel (sync + debounce + edge pulses), generate-instantiated NUM_GPIO times.
//  Top: fetch FSM, delay counter, optional IRQ logic.
// TESTING
//  1. deb_en=0, pad[3] 0->1 -> gpio_o[3]=1 after 3 edges; rise_o[3] high 1 cycle on that edge.
//  2. deb_en[0]=1, L=10, pad[0] pulse 9 cycles -> gpio_o[0] stays 0, no pulse;
//     pad held 10+ cycles -> gpio_o[0]=1 at edge 12.
//  3. FETCH_DLY=16, pad fetch high from reset -> fetch_enable_o 0 until WAIT exits, then 1;
//     pad low -> fetch_enable_o 0 after sync latency + 1.
//  4. Assert rst_n low mid-debounce and in RUN -> all outputs 0 immediately; full restart after release.
//  5. IRQ_EN, irq_fall_en[5]=1, pad[5] 1->0 -> edge_status_o[5]=1, irq_o next cycle;
//     irq_clr[5] on a new-fall edge -> status stays 1.
//  6. Without IRQ_EN, toggle all pads with all enables=1 -> edge_status_o=0, irq_o=0 throughout.

Source files
------------

// File: rtl/pulpino_fpga_pkg.sv
// Shared types and default constants for the FPGA pad conditioner.
package pulpino_fpga_pkg;

   typedef enum logic [1:0] {
      WAIT = 2'd0,
      IDLE = 2'd1,
      RUN  = 2'd2
   } fetch_state_e;

   localparam int DEF_NUM_GPIO    = 32;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_DEB_CNT_W   = 16;
   localparam int DEF_FETCH_DLY   = 1024;

endpackage

// File: rtl/pulpino_fpga_io_cond_if.sv
// Board-side pad/config bundle and SoC-side conditioned outputs of the pad conditioner.
interface pulpino_fpga_io_cond_if #(
   parameter int NUM_GPIO  = 32,
   parameter int DEB_CNT_W = 16
);
   logic [NUM_GPIO-1:0]  gpio_pad_i;
   logic [NUM_GPIO-1:0]  deb_en_i;
   logic [DEB_CNT_W-1:0] deb_limit_i;
   logic [NUM_GPIO-1:0]  gpio_o;
   logic [NUM_GPIO-1:0]  rise_o;
   logic [NUM_GPIO-1:0]  fall_o;
   logic                 fetch_enable_pad_i;
   logic                 fetch_enable_o;
   logic [NUM_GPIO-1:0]  irq_rise_en_i;
   logic [NUM_GPIO-1:0]  irq_fall_en_i;
   logic [NUM_GPIO-1:0]  irq_clr_i;
   logic [NUM_GPIO-1:0]  edge_status_o;
   logic                 irq_o;

   modport slave (
      input  gpio_pad_i, deb_en_i, deb_limit_i, fetch_enable_pad_i,
      input  irq_rise_en_i, irq_fall_en_i, irq_clr_i,
      output gpio_o, rise_o, fall_o, fetch_enable_o, edge_status_o, irq_o
   );

   modport master (
      output gpio_pad_i, deb_en_i, deb_limit_i, fetch_enable_pad_i,
      output irq_rise_en_i, irq_fall_en_i, irq_clr_i,
      input  gpio_o, rise_o, fall_o, fetch_enable_o, edge_status_o, irq_o
   );

endinterface

// File: rtl/pulpino_gpio_deb_ch.sv
// One GPIO channel: pad synchroniser, programmable debounce and registered edge pulses.
module pulpino_gpio_deb_ch
   import pulpino_fpga_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int DEB_CNT_W   = DEF_DEB_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pad,
   input  logic                 deb_en,
   input  logic [DEB_CNT_W-1:0] deb_limit,
   output logic                 level,
   output logic                 rise,
   output logic                 fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [DEB_CNT_W-1:0]   cnt_q;
   logic [DEB_CNT_W-1:0]   le_m1;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   // Limits of 0 and 1 both mean "follow the synchronised pad with no extra delay".
   assign le_m1 = (deb_en && (deb_limit > DEB_CNT_W'(1))) ? deb_limit - DEB_CNT_W'(1) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         cnt_q  <= '0;
         level  <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
         rise   <= 1'b0;
         fall   <= 1'b0;
         if (s == level) begin
            cnt_q <= '0;
         end else if (cnt_q >= le_m1) begin
            level <= s;
            cnt_q <= '0;
            rise  <= s;
            fall  <= !s;
         end else begin
            cnt_q <= cnt_q + DEB_CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/pulpino_fpga_io_cond.sv
// FPGA pad conditioner: NUM_GPIO debounced inputs, fetch-enable start sequencer, optional edge IRQ.
// Optional edge capture/IRQ logic is built when GPIO_COND_IRQ_EN is defined.
//
// state | meaning
// WAIT  | post-reset hold-off, counting FETCH_DLY cycles
// IDLE  | hold-off done, fetch disabled, waiting for synced pad high
// RUN   | fetch enabled while synced pad stays high
module pulpino_fpga_io_cond
   import pulpino_fpga_pkg::*;
#(
   parameter int NUM_GPIO    = DEF_NUM_GPIO,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int DEB_CNT_W   = DEF_DEB_CNT_W,
   parameter int FETCH_DLY   = DEF_FETCH_DLY
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pulpino_fpga_io_cond_if.slave  io
);

   localparam int DLY_W = (FETCH_DLY > 2) ? $clog2(FETCH_DLY) : 1;
   localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((FETCH_DLY > 0) ? FETCH_DLY - 1 : 0);

   logic [NUM_GPIO-1:0] gpio_q, rise_q, fall_q;

   for (genvar i = 0; i < NUM_GPIO; i++) begin : g_ch
      pulpino_gpio_deb_ch #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEB_CNT_W   (DEB_CNT_W)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .pad       (io.gpio_pad_i[i]),
         .deb_en    (io.deb_en_i[i]),
         .deb_limit (io.deb_limit_i),
         .level     (gpio_q[i]),
         .rise      (rise_q[i]),
         .fall      (fall_q[i])
      );
   end

   assign io.gpio_o = gpio_q;
   assign io.rise_o = rise_q;
   assign io.fall_o = fall_q;

   logic [SYNC_STAGES-1:0] fsync_q;
   logic                   fsync;
   fetch_state_e           state_q, state_d;
   logic [DLY_W-1:0]       dly_q, dly_d;
   logic                   fetch_en_q;

   assign fsync = fsync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      case (state_q)
         WAIT: begin
            if (dly_q == DLY_LAST) state_d = IDLE;
            else                   dly_d   = dly_q + DLY_W'(1);
         end
         IDLE:    if (fsync)  state_d = RUN;
         RUN:     if (!fsync) state_d = IDLE;
         default: state_d = WAIT;
      endcase
   end

   // Output flop follows the next state so fetch_enable_o is high exactly while in RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsync_q    <= '0;
         state_q    <= WAIT;
         dly_q      <= '0;
         fetch_en_q <= 1'b0;
      end else begin
         fsync_q    <= {fsync_q[SYNC_STAGES-2:0], io.fetch_enable_pad_i};
         state_q    <= state_d;
         dly_q      <= dly_d;
         fetch_en_q <= (state_d == RUN);
      end
   end

   assign io.fetch_enable_o = fetch_en_q;

`ifdef GPIO_COND_IRQ_EN
   logic [NUM_GPIO-1:0] status_q;
   logic                irq_q;

   // New edges are ORed in after the clear so a coincident capture is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         status_q <= (status_q & ~io.irq_clr_i)
                   | (rise_q & io.irq_rise_en_i)
                   | (fall_q & io.irq_fall_en_i);
         irq_q    <= |status_q;
      end
   end

   assign io.edge_status_o = status_q;
   assign io.irq_o         = irq_q;
`else
   logic unused_irq_in;
   assign unused_irq_in    = ^{io.irq_rise_en_i, io.irq_fall_en_i, io.irq_clr_i};
   assign io.edge_status_o = '0;
   assign io.irq_o         = 1'b0;
`endif

endmodule
